block_hit_ctrl: RTL and testbench

Access controller that owns the rotating block-row store (block_state) in the breakout core and drives all of its control inputs. It serves single-outstanding "test and clear" requests from the ball/collision logic:
- rotates the store until the requested row sits at the line output;
- tests the requested column and clears that bit by writing the row back;
- reports hit/miss.
It also keeps a pointer to the row currently at the store output, a remaining-block count and an all-clear flag, and forwards the new-game reset to the store.

---
 rtl/block_hit_ctrl_pkg.sv | 33 +++
 rtl/block_hit_ctrl_ptr.sv | 33 +++
 rtl/block_hit_ctrl.sv | 168 ++++++++++++++++
 tb/tb_block_hit_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_hit_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : block_hit_ctrl_pkg                                              |
// | Purpose  : Shared geometry constants, FSM state type and small helpers     |
// |            for the block-row store access controller.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package block_hit_ctrl_pkg;

  // Store geometry: 15 rows of 13 blocks, triangular initial fill 1+2+...+13.
  localparam int NUM_ROWS    = 15;
  localparam int LINE_WIDTH  = 13;
  localparam int INIT_BLOCKS = 91;

  // Request index widths and remaining-block counter width.
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int CNT_W = 7;

  // Controller states, explicitly two bits wide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RESP = 2'd2
  } hit_state_t;

  // Decrement that sticks at zero so the count can never wrap to 127.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_hit_ctrl_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : block_row_ptr                                                   |
// | Purpose  : Modulo-NUM_ROWS pointer shadowing which store row currently     |
// |            sits at the store line output.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module block_row_ptr #(
  parameter int NUM_ROWS = block_hit_ctrl_pkg::NUM_ROWS,
  parameter int PTR_W    = block_hit_ctrl_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(NUM_ROWS - 1);

  // Pointer follows store rotations; clear wins so a reload realigns it to row 0.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_hit_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : block_hit_ctrl                                                  |
// | Purpose  : Owns the rotating block-row store. Serves single-outstanding    |
// |            test-and-clear requests, tracks the remaining block count and   |
// |            forwards the new-game reload to the store.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module block_hit_ctrl #(
  parameter int NUM_ROWS    = block_hit_ctrl_pkg::NUM_ROWS,
  parameter int LINE_WIDTH  = block_hit_ctrl_pkg::LINE_WIDTH,
  parameter int INIT_BLOCKS = block_hit_ctrl_pkg::INIT_BLOCKS,
  parameter int ROW_W       = block_hit_ctrl_pkg::ROW_W,
  parameter int COL_W       = block_hit_ctrl_pkg::COL_W
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  new_game,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ROW_W-1:0]      req_row,
  input  logic [COL_W-1:0]      req_col,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [6:0]            blocks_left,
  output logic                  all_clear,
  input  logic [LINE_WIDTH-1:0] bs_line,
  output logic [LINE_WIDTH-1:0] bs_new_line,
  output logic                  bs_write_line,
  output logic                  bs_next_line,
  output logic                  bs_reset_state
);

  import block_hit_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_BLOCKS);

  hit_state_t            state;
  hit_state_t            state_next;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      ptr;
  logic                  accept;
  logic                  req_row_ok;
  logic                  at_row;
  logic                  col_ok;
  logic                  hit;
  logic [LINE_WIDTH-1:0] col_mask;

  // A request is taken only in IDLE and never in a new-game cycle.
  assign accept     = (state == ST_IDLE) && req_valid && !new_game;
  assign req_row_ok = int'(req_row) < NUM_ROWS;

  // The addressed row is at the store output once the pointer reaches it.
  assign at_row = (state == ST_SEEK) && (ptr == row_q);

  // One-hot column select; an out-of-range column shifts out to all zeros.
  assign col_mask = LINE_WIDTH'(1) << col_q;
  assign col_ok   = int'(col_q) < LINE_WIDTH;
  assign hit      = at_row && col_ok && (|(bs_line & col_mask));

  assign all_clear = (blocks_left == '0);

  // Row pointer mirrors the store: advances on every rotate strobe, zeroed on reload.
  block_row_ptr #(
    .NUM_ROWS (NUM_ROWS),
    .PTR_W    (ROW_W)
  ) u_row_ptr (
    .clk  (clk),
    .nRst (nRst),
    .inc  (bs_next_line),
    .clr  (new_game),
    .ptr  (ptr)
  );

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; new_game aborts whatever is in flight.
  always_comb begin
    state_next = state;
    if (new_game) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // Rows beyond the store are answered immediately as misses.
            state_next = req_row_ok ? ST_SEEK : ST_RESP;
          end
        end
        ST_SEEK: begin
          if (ptr == row_q) begin
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: handshake flags and store strobes, suppressed under new_game.
  always_comb begin
    req_ready      = (state == ST_IDLE);
    resp_valid     = (state == ST_RESP);
    bs_reset_state = new_game;
    bs_next_line   = 1'b0;
    bs_write_line  = 1'b0;
    bs_new_line    = '0;
    // The store lets a write override a reload, so nothing else may strobe now.
    if (!new_game && (state == ST_SEEK)) begin
      if (!at_row) begin
        bs_next_line = 1'b1;
      end else if (hit) begin
        bs_write_line = 1'b1;
        bs_new_line   = bs_line & ~col_mask;
      end
    end
  end

  // Capture the request so the inputs are free once it has been accepted.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      row_q <= req_row;
      col_q <= req_col;
    end
  end

  // Result flag: set in the test-and-clear cycle, held until the next response.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      resp_hit <= 1'b0;
    end else if (new_game) begin
      resp_hit <= 1'b0;
    end else if (accept && !req_row_ok) begin
      resp_hit <= 1'b0;
    end else if (at_row) begin
      resp_hit <= hit;
    end
  end

  // Remaining-block count drops by one for every block actually cleared.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      blocks_left <= INIT_CNT;
    end else if (new_game) begin
      blocks_left <= INIT_CNT;
    end else if (bs_write_line) begin
      blocks_left <= dec_sat(blocks_left);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_hit_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_block_hit_ctrl                                               |
// | Purpose  : Self-checking bench for block_hit_ctrl with a behavioural       |
// |            block-row store and a reference model of the hit rules.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_block_hit_ctrl;

  localparam int NR = 15;
  localparam int LW = 13;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        new_game = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_row = '0;
  logic [3:0]  req_col = '0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic [6:0]  blocks_left;
  logic        all_clear;
  logic [12:0] bs_line;
  logic [12:0] bs_new_line;
  logic        bs_write_line;
  logic        bs_next_line;
  logic        bs_reset_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  block_hit_ctrl dut (
    .clk            (clk),
    .nRst           (nRst),
    .new_game       (new_game),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_row        (req_row),
    .req_col        (req_col),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .blocks_left    (blocks_left),
    .all_clear      (all_clear),
    .bs_line        (bs_line),
    .bs_new_line    (bs_new_line),
    .bs_write_line  (bs_write_line),
    .bs_next_line   (bs_next_line),
    .bs_reset_state (bs_reset_state)
  );

  // Initial content of row k: k-1 blocks packed at the low end (rows 0,1 empty).
  function automatic logic [12:0] init_row(input int k);
    logic [12:0] v;
    v = '0;
    for (int b = 0; b < k - 1; b++) v[b] = 1'b1;
    return v;
  endfunction

  // Behavioural rotating store driven only by the DUT strobes.
  logic [12:0] store [NR];
  int          sptr;
  assign bs_line = store[sptr];

  always @(posedge clk or negedge nRst) begin
    if (!nRst || bs_reset_state && !bs_write_line) begin
      for (int k = 0; k < NR; k++) store[k] <= init_row(k);
      sptr <= 0;
    end else if (bs_write_line) begin
      store[sptr] <= bs_new_line;
    end else if (bs_next_line) begin
      sptr <= (sptr == NR - 1) ? 0 : sptr + 1;
    end
  end

  // Reference model: block map, row at the output, remaining blocks.
  logic [12:0] gold [NR];
  int          mptr;
  int          mcount;

  task automatic model_reset();
    for (int k = 0; k < NR; k++) gold[k] = init_row(k);
    mptr   = 0;
    mcount = 91;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request/response; called and returning on a negedge in IDLE.
  task automatic do_req(input int row, input int col, input string tag, output logic got_hit);
    int          d;
    int          exp_lat;
    int          cyc;
    int          nl;
    int          wr;
    logic        exp_hit;
    logic [12:0] exp_wdata;
    logic [12:0] wdata;
    logic        clash;
    logic        seen;
    exp_hit   = 1'b0;
    exp_wdata = '0;
    d         = 0;
    exp_lat   = 1;
    if (row < NR) begin
      d       = (row - mptr + NR) % NR;
      exp_lat = 2 + d;
      if (col < LW) exp_hit = gold[row][col];
    end
    if (exp_hit) exp_wdata = gold[row] & ~(13'(1) << col);

    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_row   = 4'(row);
    req_col   = 4'(col);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nl = 0; wr = 0; wdata = '0; clash = 1'b0; seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (bs_next_line) nl++;
      if (bs_write_line) begin
        wr++;
        wdata = bs_new_line;
      end
      if ((bs_next_line && bs_write_line) || bs_reset_state) clash = 1'b1;
      if (resp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    got_hit = resp_hit;
    chk({tag, " resp_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " resp_hit"}, 32'(resp_hit), 32'(exp_hit));
    chk({tag, " rotations"}, 32'(nl), 32'(d));
    chk({tag, " writes"}, 32'(wr), 32'(exp_hit));
    chk({tag, " new_line"}, 32'(wdata), 32'(exp_wdata));
    chk({tag, " strobe_clash"}, 32'(clash), 32'd0);

    if (row < NR) begin
      mptr = row;
      if (exp_hit) begin
        gold[row] = exp_wdata;
        if (mcount > 0) mcount--;
      end
    end
    chk({tag, " blocks_left"}, 32'(blocks_left), 32'(mcount));
    chk({tag, " all_clear"}, 32'(all_clear), 32'(mcount == 0));

    @(negedge clk);
    chk({tag, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
    chk({tag, " hit_hold"}, 32'(resp_hit), 32'(exp_hit));
  endtask

  logic h;
  int   hits;
  int   tr;
  int   resp_cnt;
  int   strobe_cnt;

  initial begin
    model_reset();
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_hit", 32'(resp_hit), 32'd0);
    chk("rst blocks_left", 32'(blocks_left), 32'd91);
    chk("rst all_clear", 32'(all_clear), 32'd0);
    chk("rst strobes", 32'({bs_write_line, bs_next_line, bs_reset_state}), 32'd0);
    chk("rst new_line", 32'(bs_new_line), 32'd0);
    nRst = 1'b1;
    @(negedge clk);

    // Far row: 14 rotations, clears top bit of row 14.
    do_req(14, 12, "t1", h);
    chk("t1 count90", 32'(blocks_left), 32'd90);
    // Same block again: no rotation, miss.
    do_req(14, 12, "t2", h);
    // Wrap 14->0->1->2, then repeat to miss.
    do_req(2, 0, "t3a", h);
    chk("t3 count89", 32'(blocks_left), 32'd89);
    do_req(2, 0, "t3b", h);
    // Rejected row and out-of-range column.
    do_req(15, 0, "t4a", h);
    do_req(3, 13, "t4b", h);

    // new_game in the middle of a 10-rotation seek.
    tr = (mptr + 10) % NR;
    req_valid = 1'b1;
    req_row   = 4'(tr);
    req_col   = 4'd0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5 seek_pulse", 32'(bs_next_line), 32'd1);
      @(negedge clk);
    end
    new_game = 1'b1;
    #1;
    chk("t5 reset_state", 32'(bs_reset_state), 32'd1);
    chk("t5 other_strobes", 32'({bs_write_line, bs_next_line}), 32'd0);
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    resp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) resp_cnt++;
      @(negedge clk);
    end
    chk("t5 no_resp", 32'(resp_cnt), 32'd0);
    chk("t5 blocks_left", 32'(blocks_left), 32'd91);
    chk("t5 idle", 32'(req_ready), 32'd1);
    // Pointer back at 0: row 3 needs exactly 3 rotations.
    do_req(3, 1, "t5 realign", h);

    // Request presented in the same cycle as new_game is ignored.
    new_game  = 1'b1;
    req_valid = 1'b1;
    req_row   = 4'd5;
    req_col   = 4'd0;
    @(negedge clk);
    new_game  = 1'b0;
    req_valid = 1'b0;
    model_reset();
    resp_cnt = 0;
    strobe_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) resp_cnt++;
      if (bs_next_line || bs_write_line) strobe_cnt++;
      @(negedge clk);
    end
    chk("ng_req ignored_resp", 32'(resp_cnt), 32'd0);
    chk("ng_req ignored_strobe", 32'(strobe_cnt), 32'd0);

    // Randomized requests checked against the model.
    for (int i = 0; i < 40; i++) begin
      do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand", h);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Fresh game, sweep every block: all 91 present blocks must hit.
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    chk("sweep start_count", 32'(blocks_left), 32'd91);
    hits = 0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < LW; c++) begin
        do_req(r, c, "sweep", h);
        hits += int'(h);
      end
    end
    chk("sweep hits", 32'(hits), 32'd91);
    chk("sweep all_clear", 32'(all_clear), 32'd1);
    chk("sweep blocks_left", 32'(blocks_left), 32'd0);
    for (int i = 0; i < 6; i++) begin
      do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "post", h);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
